// File: rtl/miriscv_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and LSU.
// One transaction in flight; a watchdog answers on behalf of silent memory.
module miriscv_mem_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              arstn_i,

  input  logic              i_req_i,
  input  logic [XLEN-1:0]   i_addr_i,
  output logic              i_rvalid_o,
  output logic [XLEN-1:0]   i_rdata_o,
  output logic              i_err_o,

  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [XLEN/8-1:0] d_be_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic [XLEN-1:0]   d_wdata_i,
  output logic              d_rvalid_o,
  output logic [XLEN-1:0]   d_rdata_o,
  output logic              d_err_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,

  output logic              busy_o
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e            state_q;
  logic              owner_d_q;
  logic              last_d_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;

  logic              any_req;
  logic              grant_d;
  logic              to_hit;
  logic              resp;
  logic [XLEN-1:0]   resp_data;

  assign any_req = i_req_i | d_req_i;
  // D wins when alone, or on a tie when I was granted last.
  assign grant_d = d_req_i & (~i_req_i | ~last_d_q);

  assign to_hit    = TO_EN & (cnt_q == TO_LAST);
  assign resp      = (state_q == WAIT) & (mem_rvalid_i | to_hit);
  assign resp_data = mem_rvalid_i ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b1;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      req_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q   <= ISSUE;
            req_q     <= 1'b1;
            owner_d_q <= grant_d;
            last_d_q  <= grant_d;
            we_q      <= grant_d & d_we_i;
            be_q      <= grant_d ? d_be_i : '1;
            addr_q    <= grant_d ? d_addr_i : i_addr_i;
            wdata_q   <= grant_d ? d_wdata_i : '0;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: begin
          if (mem_rvalid_i || to_hit) begin
            state_q <= IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != IDLE);

  assign i_rvalid_o = resp & ~owner_d_q;
  assign d_rvalid_o = resp & owner_d_q;
  assign i_rdata_o  = i_rvalid_o ? resp_data : '0;
  assign d_rdata_o  = d_rvalid_o ? resp_data : '0;
  assign i_err_o    = i_rvalid_o & ~mem_rvalid_i;
  assign d_err_o    = d_rvalid_o & ~mem_rvalid_i;

endmodule

// File: doc/miriscv_mem_arbiter.md
Name: miriscv_mem_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester (I) and the data LSU requester (D).
- Sits between the fetch stage / LSU and the single memory port; one transaction outstanding at a time.
- Arbitration is round-robin; responses are routed back to the owner.
- A watchdog counter terminates transactions the memory never answers.

Parameters:
XLEN, 32, data/address width.
TIMEOUT_CYCLES, 255, max WAIT cycles before forced error response; 0 disables the watchdog.

Ports:
clk_i  input  1  clock
arstn_i  input  1  asynchronous active-low reset
i_req_i  input  1  fetch request, held until i_rvalid_o
i_addr_i  input  XLEN  fetch address
i_rvalid_o  output  1  fetch response valid (1-cycle pulse)
i_rdata_o  output  XLEN  fetch response data
i_err_o  output  1  fetch timeout error, qualified by i_rvalid_o
d_req_i  input  1  data request, held until d_rvalid_o
d_we_i  input  1  data write enable
d_be_i  input  XLEN/8  data byte enables
d_addr_i  input  XLEN  data address
d_wdata_i  input  XLEN  write data
d_rvalid_o  output  1  data response valid (1-cycle pulse)
d_rdata_o  output  XLEN  data response data
d_err_o  output  1  data timeout error, qualified by d_rvalid_o
mem_req_o  output  1  memory request (1-cycle pulse)
mem_we_o  output  1  memory write enable
mem_be_o  output  XLEN/8  memory byte enables
mem_addr_o  output  XLEN  memory address
mem_wdata_o  output  XLEN  memory write data
mem_rvalid_i  input  1  memory response valid
mem_rdata_i  input  XLEN  memory response data
busy_o  output  1  transaction in flight (state != IDLE)

Behaviour:
- Reset: arstn_i is asynchronous, active-low; clock is clk_i. On reset: state=IDLE, owner=D, last_grant=I (so D wins the first tie), timeout counter=0.
- Outputs during reset: all mem_* outputs 0; all *_rvalid_o, *_rdata_o, *_err_o 0; busy_o 0.
- Requester contract: the requester holds req and its attributes stable until its rvalid pulse. In the rvalid cycle its req is ignored; a still-high req is treated as a new request from the next cycle.
- IDLE:
  - One requester active: it wins.
  - Both active: the one not equal to last_grant wins.
  - On grant, register owner, last_grant, and attributes, then go to ISSUE.
  - I grant forces we=0, be=all ones, wdata=0.
- ISSUE (exactly 1 cycle):
  - mem_req_o=1 with the registered attributes; counter cleared. Go to WAIT.
  - Memory never answers in the same cycle as mem_req_o.
- WAIT:
  - mem_req_o=0; mem_we/be/addr/wdata hold their values.
  - On mem_rvalid_i: combinationally drive the owner's rvalid_o=1, rdata_o=mem_rdata_i, err_o=0; next state IDLE.
  - Otherwise the counter increments.
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no rvalid: owner rvalid_o=1, rdata_o=0, err_o=1; next state IDLE.
  - If rvalid and timeout coincide, rvalid wins with err=0.
- Non-owner port: rvalid/rdata/err are 0 at all times.
- Stray mem_rvalid_i outside WAIT (e.g. a late answer after timeout): ignored, with no output effect.
- Throughput: request seen in IDLE at cycle N gives mem_req_o at N+1 and response at ≥N+2. Back-to-back minimum is 3 cycles per transaction.
- Fairness: with both requesters continuously active, grants alternate I/D strictly.
- Counter width: clog2(TIMEOUT_CYCLES+1), minimum 1; it never wraps, because the timeout exits WAIT first.
- Reset asserted mid-transaction: immediate return to reset values; the in-flight response is dropped and no rvalid is produced.

Test Plan:
- Single fetch: i_req_i=1, i_addr_i=0x80, memory answers 2 cycles after mem_req_o with 0x00000013 -> mem_req_o 1 cycle later with addr 0x80, we=0, be=0xF. Then i_rvalid_o pulse with rdata 0x00000013 and i_err_o=0; d_rvalid_o stays 0.
- Tie after reset: i_req_i and d_req_i both high, held -> first grant D, then I, then D. mem_req_o pulses every 3 cycles with matching addresses.
- Data store: d_we=1, be=0x3, addr=0x1004, wdata=0xDEADBEEF -> mem outputs carry exactly these values. d_rvalid_o pulses on mem_rvalid_i.
- Timeout: TIMEOUT_CYCLES=4, memory silent -> d_rvalid_o=1, d_err_o=1, d_rdata_o=0 on the 4th WAIT cycle, then IDLE. A later mem_rvalid_i produces no output pulse.
- Coincidence: mem_rvalid_i arrives in the same cycle the timeout would fire -> rvalid with mem_rdata_i and err=0.
- Reset mid-WAIT: arstn_i low during WAIT -> all outputs 0 immediately and busy_o=0. After release, a pending request is re-arbitrated from IDLE.
